// File: rtl/serv_rf_ram_if_if.sv
// Bundle of the core-side serial RF port and the RAM-side word port of serv_rf_ram_if.
// The bridge itself uses the slave view; whatever models the core and the RAM uses master.
interface serv_rf_ram_if_if #(
   parameter int WIDTH    = 8,
   parameter int CSR_REGS = 4
);
   localparam int DEPTH = (32 + CSR_REGS) * 32 / WIDTH;
   localparam int AW    = $clog2(DEPTH);

   logic             i_rreq;
   logic             i_wreq;
   logic             o_ready;
   logic [5:0]       i_rreg0;
   logic [5:0]       i_rreg1;
   logic             o_rdata0;
   logic             o_rdata1;
   logic [5:0]       i_wreg0;
   logic [5:0]       i_wreg1;
   logic             i_wen0;
   logic             i_wen1;
   logic             i_wdata0;
   logic             i_wdata1;
   logic [AW-1:0]    o_raddr;
   logic [WIDTH-1:0] i_rdata;
   logic [AW-1:0]    o_waddr;
   logic [WIDTH-1:0] o_wdata;
   logic             o_wen;

   modport slave (
      input  i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
             i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
      output o_ready, o_rdata0, o_rdata1, o_raddr, o_waddr, o_wdata, o_wen
   );

   modport master (
      output i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
             i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
      input  o_ready, o_rdata0, o_rdata1, o_raddr, o_waddr, o_wdata, o_wen
   );
endinterface

// File: rtl/serv_rf_ram_if.sv
// Bridges SERV's two bit-serial RF read/write streams onto a WIDTH-bit synchronous RAM.
// cnt counts cycles since the request was accepted (1 on the first cycle out of IDLE).
//
//   state  | meaning
//   IDLE   | waiting for i_rreq (priority) or i_wreq; prefetches rreg0 word 0
//   READ   | fetch rreg0/rreg1 words, shift out both streams for 32 cycles
//   WRITE  | assemble words from both streams, write each on completion
//   WFLUSH | last stream-1 word write
module serv_rf_ram_if #(
   parameter int WIDTH    = 8,
   parameter int CSR_REGS = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   serv_rf_ram_if_if.slave  bus
);
   localparam int DEPTH = (32 + CSR_REGS) * 32 / WIDTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int WPR   = 32 / WIDTH;
   localparam int PB    = $clog2(WPR);
   localparam int WB    = $clog2(WIDTH);
   localparam logic [5:0] WM = 6'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, WFLUSH} state_t;

   state_t           state, state_nxt;
   logic [5:0]       cnt;
   logic [5:0]       rreg0, rreg1, wreg0, wreg1;
   logic             wen0, wen1;
   logic [WIDTH-1:0] rsh0, rsh1, rhold0;
   logic [WIDTH-1:0] wbuf0, wbuf1, wsave1;

   logic [5:0]       cnt_m2, cnt_m3;
   logic             rd_cap, rd_load, rd_last, wshift, ev0, ev1;
   logic             ready;
   logic [AW-1:0]    raddr, waddr;
   logic [WIDTH-1:0] wdata;
   logic             wen;

   function automatic logic [AW-1:0] ram_addr(input logic [5:0] r, input logic [5:0] w);
      return AW'(({26'd0, r} << PB) | ({26'd0, w} & 32'(WPR - 1)));
   endfunction

   assign cnt_m2 = cnt - 6'd2;
   assign cnt_m3 = cnt - 6'd3;

   // Word k of both read streams is loaded at cnt = k*WIDTH+2; rreg0's word arrives one cycle earlier and waits in rhold0.
   assign rd_cap  = (state == READ) && ((cnt & WM) == 6'd1);
   assign rd_load = (state == READ) && ((cnt_m2 & WM) == 6'd0) && (cnt >= 6'd2) && (cnt <= 6'd33);
   assign rd_last = (state == READ) && (cnt == 6'd34);

   assign wshift = (state == WRITE) && (cnt >= 6'd2) && (cnt <= 6'd33);
   assign ev0    = (state == WRITE) && (cnt >= 6'(2 + WIDTH)) && ((cnt_m2 & WM) == 6'd0);
   assign ev1    = ((state == WRITE) || (state == WFLUSH)) &&
                   (cnt >= 6'(3 + WIDTH)) && ((cnt_m3 & WM) == 6'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         rreg0  <= 6'd0;
         rreg1  <= 6'd0;
         wreg0  <= 6'd0;
         wreg1  <= 6'd0;
         wen0   <= 1'b0;
         wen1   <= 1'b0;
         rsh0   <= '0;
         rsh1   <= '0;
         rhold0 <= '0;
         wbuf0  <= '0;
         wbuf1  <= '0;
         wsave1 <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == IDLE) ? 6'd1 : cnt + 6'd1;
         if (state == IDLE) begin
            if (bus.i_rreq) begin
               rreg0 <= bus.i_rreg0;
               rreg1 <= bus.i_rreg1;
            end else if (bus.i_wreq) begin
               wreg0 <= bus.i_wreg0;
               wreg1 <= bus.i_wreg1;
               wen0  <= bus.i_wen0;
               wen1  <= bus.i_wen1;
            end
         end
         if (rd_cap)
            rhold0 <= bus.i_rdata;
         if (rd_last) begin
            rsh0 <= '0;
            rsh1 <= '0;
         end else if (rd_load) begin
            rsh0 <= (rreg0 == 6'd0) ? '0 : rhold0;
            rsh1 <= (rreg1 == 6'd0) ? '0 : bus.i_rdata;
         end else if (state == READ) begin
            rsh0 <= rsh0 >> 1;
            rsh1 <= rsh1 >> 1;
         end
         if (wshift) begin
            wbuf0 <= {bus.i_wdata0, wbuf0[WIDTH-1:1]};
            wbuf1 <= {bus.i_wdata1, wbuf1[WIDTH-1:1]};
         end
         // Stream 1 is written a cycle late, after wbuf1 has already taken the next bit.
         if (ev0)
            wsave1 <= wbuf1;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      raddr     = '0;
      case (state)
         IDLE: begin
            if (bus.i_rreq) begin
               state_nxt = READ;
               raddr     = ram_addr(bus.i_rreg0, 6'd0);
            end else if (bus.i_wreq) begin
               state_nxt = WRITE;
            end
         end
         READ: begin
            ready = (cnt == 6'd2);
            raddr = ram_addr(((cnt & WM) == 6'd0) ? rreg0 : rreg1, cnt >> WB);
            if (cnt == 6'd34)
               state_nxt = IDLE;
         end
         WRITE: begin
            ready = (cnt == 6'd1);
            if (cnt == 6'd34)
               state_nxt = WFLUSH;
         end
         WFLUSH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wen   = (ev0 && wen0) || (ev1 && wen1);
      waddr = '0;
      wdata = '0;
      if (ev0) begin
         waddr = ram_addr(wreg0, (cnt_m2 >> WB) - 6'd1);
         wdata = wbuf0;
      end else if (ev1) begin
         waddr = ram_addr(wreg1, (cnt_m3 >> WB) - 6'd1);
         wdata = wsave1;
      end
   end

   assign bus.o_ready  = ready;
   assign bus.o_rdata0 = rsh0[0];
   assign bus.o_rdata1 = rsh1[0];
   assign bus.o_raddr  = raddr;
   assign bus.o_waddr  = waddr;
   assign bus.o_wdata  = wdata;
   assign bus.o_wen    = wen;
endmodule

// File: tb/tb_serv_rf_ram_if.sv
// Drives identical RF traffic into three bridges (WIDTH 2, 8, 32), each backed by its own RAM model.
module tb_serv_rf_ram_if;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rreq, wreq, wen0, wen1, wd0, wd1;
   logic [5:0]  rreg0, rreg1, wreg0, wreg1;
   logic        pl_en;
   logic [5:0]  pl_reg;
   logic [31:0] pl_val;

   logic        rdy [3];
   logic        rd0 [3];
   logic        rd1 [3];
   logic        wen [3];
   logic [31:0] ra  [3];
   logic [31:0] wa  [3];
   logic [31:0] wdat [3];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic int wof(input int g);
      return (g == 0) ? 2 : (g == 1) ? 8 : 32;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gen_w
      localparam int W   = (g == 0) ? 2 : (g == 1) ? 8 : 32;
      localparam int WPR = 32 / W;
      localparam int PB  = $clog2(WPR);

      serv_rf_ram_if_if #(.WIDTH(W), .CSR_REGS(4)) bus ();

      serv_rf_ram_if #(.WIDTH(W), .CSR_REGS(4)) dut (
         .i_clk (clk),
         .i_rst (rst),
         .bus   (bus)
      );

      logic [31:0]  regs [36];
      logic [W-1:0] rq;
      int           wrow, wwrd, rrow, rwrd;

      always_comb begin
         wrow = int'(bus.o_waddr) >> PB;
         wwrd = int'(bus.o_waddr) & (WPR - 1);
         rrow = int'(bus.o_raddr) >> PB;
         rwrd = int'(bus.o_raddr) & (WPR - 1);
      end

      always @(posedge clk) begin
         if (pl_en)
            regs[pl_reg] <= pl_val;
         if (bus.o_wen)
            regs[wrow][wwrd*W +: W] <= bus.o_wdata;
         rq <= W'(regs[rrow] >> (rwrd * W));
      end

      assign bus.i_rreq   = rreq;
      assign bus.i_wreq   = wreq;
      assign bus.i_rreg0  = rreg0;
      assign bus.i_rreg1  = rreg1;
      assign bus.i_wreg0  = wreg0;
      assign bus.i_wreg1  = wreg1;
      assign bus.i_wen0   = wen0;
      assign bus.i_wen1   = wen1;
      assign bus.i_wdata0 = wd0;
      assign bus.i_wdata1 = wd1;
      assign bus.i_rdata  = rq;

      assign rdy[g]  = bus.o_ready;
      assign rd0[g]  = bus.o_rdata0;
      assign rd1[g]  = bus.o_rdata1;
      assign wen[g]  = bus.o_wen;
      assign ra[g]   = 32'(bus.o_raddr);
      assign wa[g]   = 32'(bus.o_waddr);
      assign wdat[g] = 32'(bus.o_wdata);
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [5:0] r, input logic [31:0] v);
      pl_en  = 1'b1;
      pl_reg = r;
      pl_val = v;
      next_cyc;
      pl_en  = 1'b0;
   endtask

   // Request at the current cycle T; returns at the start of T+35, when the next request may go out.
   task automatic do_read(input logic [5:0] r0, input logic [5:0] r1,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input bit both, input bit extra);
      logic [31:0] got0 [3];
      logic [31:0] got1 [3];
      int nrdy [3];
      int rdyc [3];
      int nwen [3];
      for (int g = 0; g < 3; g++) begin
         got0[g] = '0; got1[g] = '0; nrdy[g] = 0; rdyc[g] = -1; nwen[g] = 0;
      end
      rreq  = 1'b1;
      rreg0 = r0;
      rreg1 = r1;
      if (both) begin
         wreq = 1'b1; wreg0 = 6'd12; wreg1 = 6'd13; wen0 = 1'b1; wen1 = 1'b1;
      end
      next_cyc;
      rreq = 1'b0;
      wreq = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         if (extra && c == 10) begin
            rreq = 1'b1; rreg0 = 6'd7; rreg1 = 6'd33;
         end else begin
            rreq = 1'b0;
         end
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            if (rdy[g]) begin nrdy[g]++; rdyc[g] = c; end
            if (wen[g]) nwen[g]++;
            if (c >= 3) begin
               got0[g][c-3] = rd0[g];
               got1[g][c-3] = rd1[g];
            end
         end
         next_cyc;
      end
      rreq = 1'b0;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rd grant cycle W%0d", wof(g)), 32'(rdyc[g]), 32'd2);
         chk($sformatf("rd grant count W%0d", wof(g)), 32'(nrdy[g]), 32'd1);
         chk($sformatf("rdata0 r%0d W%0d", r0, wof(g)), got0[g], e0);
         chk($sformatf("rdata1 r%0d W%0d", r1, wof(g)), got1[g], e1);
         if (both || extra)
            chk($sformatf("wen during read W%0d", wof(g)), 32'(nwen[g]), 32'd0);
      end
   endtask

   // Request at cycle T; reset is raised at the start of cycle T+cut. Returns at the start of T+36.
   task automatic do_write(input logic [5:0] r0, input bit e0, input logic [31:0] d0,
                           input logic [5:0] r1, input bit e1, input logic [31:0] d1,
                           input int cut);
      int nrdy [3];
      int rdyc [3];
      for (int g = 0; g < 3; g++) begin
         nrdy[g] = 0; rdyc[g] = -1;
      end
      wreq  = 1'b1;
      wreg0 = r0; wen0 = e0;
      wreg1 = r1; wen1 = e1;
      next_cyc;
      wreq = 1'b0;
      for (int c = 1; c <= 35; c++) begin
         if (c >= 2 && c <= 33) begin
            wd0 = d0[c-2];
            wd1 = d1[c-2];
         end else begin
            wd0 = 1'b0;
            wd1 = 1'b0;
         end
         if (c == cut) rst = 1'b1;
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            int w, k, ea;
            bit s0, s1, ew;
            logic [63:0] m;
            logic [31:0] d;
            w  = wof(g);
            s0 = (c < cut) && (c >= 2 + w) && ((c - 2) % w == 0) && (c <= 34);
            s1 = (c < cut) && (c >= 3 + w) && ((c - 3) % w == 0);
            ew = (s0 && e0) || (s1 && e1);
            if (rdy[g]) begin nrdy[g]++; rdyc[g] = c; end
            if (ew || wen[g]) begin
               chk($sformatf("wen c%0d W%0d", c, w), 32'(wen[g]), 32'(ew));
               if (ew) begin
                  k  = s0 ? (c - 2) / w - 1 : (c - 3) / w - 1;
                  ea = (s0 ? int'(r0) : int'(r1)) * (32 / w) + k;
                  d  = s0 ? d0 : d1;
                  m  = (64'd1 << w) - 64'd1;
                  chk($sformatf("waddr c%0d W%0d", c, w), wa[g], 32'(ea));
                  chk($sformatf("wdata c%0d W%0d", c, w), wdat[g], (d >> (k * w)) & m[31:0]);
               end
            end
         end
         next_cyc;
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("wr grant cycle W%0d", wof(g)), 32'(rdyc[g]), 32'd1);
         chk($sformatf("wr grant count W%0d", wof(g)), 32'(nrdy[g]), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; rreq = 1'b1; wreq = 1'b1;
      rreg0 = 6'd5; rreg1 = 6'd10; wreg0 = 6'd7; wreg1 = 6'd33;
      wen0 = 1'b1; wen1 = 1'b1; wd0 = 1'b1; wd1 = 1'b1;
      pl_en = 1'b0; pl_reg = 6'd0; pl_val = 32'd0;

      // Reset held while both requests are pending.
      repeat (3) next_cyc;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst ready W%0d", wof(g)), 32'(rdy[g]), 32'd0);
         chk($sformatf("rst rdata0 W%0d", wof(g)), 32'(rd0[g]), 32'd0);
         chk($sformatf("rst rdata1 W%0d", wof(g)), 32'(rd1[g]), 32'd0);
         chk($sformatf("rst wen W%0d", wof(g)), 32'(wen[g]), 32'd0);
         chk($sformatf("rst waddr W%0d", wof(g)), wa[g], 32'd0);
         chk($sformatf("rst wdata W%0d", wof(g)), wdat[g], 32'd0);
      end
      next_cyc;
      rreq = 1'b0; wreq = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 3; g++)
         chk($sformatf("rst raddr W%0d", wof(g)), ra[g], 32'd0);
      next_cyc;
      rst = 1'b0;

      preload(6'd0,  32'hFFFF_FFFF);
      preload(6'd5,  32'hDEAD_BEEF);
      preload(6'd10, 32'h1234_5678);
      preload(6'd7,  32'h0000_0000);
      preload(6'd33, 32'h0000_0000);
      preload(6'd12, 32'h0000_0000);
      preload(6'd13, 32'h0000_0000);
      preload(6'd20, 32'h0000_0000);
      preload(6'd21, 32'h0000_0000);

      do_read(6'd5, 6'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
      // Issued at T+35 of the previous read.
      do_read(6'd0, 6'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

      do_write(6'd7, 1'b1, 32'hA5A5_C3C3, 6'd33, 1'b1, 32'h0000_F00D, 99);
      do_read(6'd7, 6'd33, 32'hA5A5_C3C3, 32'h0000_F00D, 1'b0, 1'b0);
      do_write(6'd7, 1'b0, 32'h1111_1111, 6'd33, 1'b1, 32'hCAFE_0001, 99);
      do_read(6'd7, 6'd33, 32'hA5A5_C3C3, 32'hCAFE_0001, 1'b0, 1'b0);

      // Simultaneous read+write request, then a stray read request mid-read.
      do_read(6'd5, 6'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
      next_cyc;

      do_write(6'd20, 1'b1, 32'hAABB_CCDD, 6'd21, 1'b1, 32'h1122_3344, 12);
      rst = 1'b0;
      next_cyc;
      chk("rst-mid-write row20 W8", gen_w[1].regs[20], 32'h0000_00DD);
      chk("rst-mid-write row21 W8", gen_w[1].regs[21], 32'h0000_0044);
      do_read(6'd5, 6'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
